// File: rtl/msu_ctrl_pkg.sv
// Shared control definitions for the modular-squaring iteration sequencer.
package msu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_DONE   = 3'd3,
    S_ERROR  = 3'd4
  } msu_state_e;

  // Cycles allowed between squarer completions before declaring a hang.
  localparam int WDOG_CYC_DEF = 15;

endpackage

// File: rtl/modsq_iter_sequencer.sv
// Sequences T back-to-back modular squarings on an external squarer.
// The squarer flips sq_valid_toggle once per finished squaring; this block
// counts flips, captures the last result and guards against a stalled squarer.
module modsq_iter_sequencer
  import msu_ctrl_pkg::*;
#(
  parameter int MOD_LEN  = 1024,
  parameter int T_LEN    = 64,
  parameter int WDOG_CYC = WDOG_CYC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_req,
  input  logic               abort,
  input  logic [T_LEN-1:0]   t_target,
  input  logic [MOD_LEN-1:0] x_in,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [MOD_LEN-1:0] result,
  output logic [T_LEN-1:0]   iter_count,
  output logic               sq_reset,
  output logic               sq_start,
  output logic [MOD_LEN-1:0] sq_in,
  input  logic [MOD_LEN-1:0] sq_out,
  input  logic               sq_valid_toggle
);

  localparam int WD_W = (WDOG_CYC < 2) ? 1 : $clog2(WDOG_CYC + 1);

  msu_state_e          state;
  logic [MOD_LEN-1:0]  x_lat;
  logic [T_LEN-1:0]    t_lat;
  logic                prev_toggle;
  logic [WD_W-1:0]     wdog;
  logic [T_LEN-1:0]    iter_nxt;
  logic                sq_cpl;

  // The squarer always works on the operand captured at acceptance.
  assign sq_in    = x_lat;
  assign iter_nxt = iter_count + T_LEN'(1);
  assign sq_cpl   = (sq_valid_toggle != prev_toggle);

  // Control FSM; every output is registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      sq_start    <= 1'b0;
      sq_reset    <= 1'b1;
      result      <= '0;
      iter_count  <= '0;
      prev_toggle <= 1'b0;
      x_lat       <= '0;
      t_lat       <= '0;
      wdog        <= '0;
    end else begin
      done     <= 1'b0;
      sq_start <= 1'b0;
      case (state)
        // ERROR accepts a new run exactly like IDLE does (and clears err).
        S_IDLE, S_ERROR: begin
          if (start_req) begin
            x_lat      <= x_in;
            t_lat      <= t_target;
            iter_count <= '0;
            err        <= 1'b0;
            wdog       <= '0;
            ready      <= 1'b0;
            if (t_target == '0) begin
              // Zero squarings: the operand itself is the answer.
              state    <= S_DONE;
              result   <= x_in;
              done     <= 1'b1;
              sq_reset <= 1'b1;
              busy     <= 1'b0;
            end else begin
              state    <= S_LAUNCH;
              sq_start <= 1'b1;
              sq_reset <= 1'b0;
              busy     <= 1'b1;
            end
          end else if (state == S_IDLE) begin
            sq_reset <= 1'b0;
          end
        end

        S_LAUNCH: begin
          if (abort) begin
            state    <= S_IDLE;
            sq_reset <= 1'b1;
            ready    <= 1'b1;
            busy     <= 1'b0;
          end else begin
            // Reference level for edge-free completion detection.
            prev_toggle <= sq_valid_toggle;
            wdog        <= '0;
            state       <= S_RUN;
          end
        end

        S_RUN: begin
          if (abort) begin
            // Abort beats a same-cycle completion; result is left alone.
            state    <= S_IDLE;
            sq_reset <= 1'b1;
            ready    <= 1'b1;
            busy     <= 1'b0;
          end else if (sq_cpl) begin
            prev_toggle <= sq_valid_toggle;
            iter_count  <= iter_nxt;
            wdog        <= '0;
            if (iter_nxt == t_lat) begin
              result   <= sq_out;
              state    <= S_DONE;
              done     <= 1'b1;
              sq_reset <= 1'b1;
              busy     <= 1'b0;
            end
          end else if (wdog == WD_W'(WDOG_CYC - 1)) begin
            // Squarer stalled: park it in reset until a new run is accepted.
            state    <= S_ERROR;
            err      <= 1'b1;
            sq_reset <= 1'b1;
            busy     <= 1'b0;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end

        S_DONE: begin
          state    <= S_IDLE;
          sq_reset <= 1'b0;
          ready    <= 1'b1;
        end

        default: begin
          state    <= S_IDLE;
          sq_reset <= 1'b1;
          ready    <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modsq_iter_sequencer.sv
// Directed bench for modsq_iter_sequencer with a small Montgomery squarer stub
// (N = 251, R = 2^16) that flips its toggle every three cycles once started.
module tb_modsq_iter_sequencer;
  localparam int MOD_LEN = 16;
  localparam int T_LEN   = 8;
  localparam int WDOG    = 15;
  localparam longint MODN = 251;
  localparam logic [15:0] R_MOD_N = 16'd25;   // 65536 mod 251

  logic               clk = 1'b0;
  logic               reset;
  logic               start_req = 1'b0;
  logic               abort = 1'b0;
  logic [T_LEN-1:0]   t_target = '0;
  logic [MOD_LEN-1:0] x_in = '0;
  logic               ready, busy, done, err, sq_reset, sq_start;
  logic [MOD_LEN-1:0] result, sq_in, sq_out;
  logic [T_LEN-1:0]   iter_count;
  logic               sq_valid_toggle;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  int at;
  logic [15:0] gold;

  always #5 clk = ~clk;

  modsq_iter_sequencer #(.MOD_LEN(MOD_LEN), .T_LEN(T_LEN), .WDOG_CYC(WDOG)) dut (
    .clk(clk), .reset(reset), .start_req(start_req), .abort(abort),
    .t_target(t_target), .x_in(x_in), .ready(ready), .busy(busy), .done(done),
    .err(err), .result(result), .iter_count(iter_count), .sq_reset(sq_reset),
    .sq_start(sq_start), .sq_in(sq_in), .sq_out(sq_out),
    .sq_valid_toggle(sq_valid_toggle)
  );

  // a*a*R^-1 mod N, bit-serial REDC
  function automatic logic [15:0] mont_sq(input logic [15:0] a);
    longint t = 0;
    for (int i = 0; i < 16; i++) begin
      if (a[i]) t += longint'(a);
      if (t[0]) t += MODN;
      t = t >>> 1;
    end
    if (t >= MODN) t -= MODN;
    return 16'(t);
  endfunction

  // squarer stub
  logic       stall = 1'b0;
  logic       s_run;
  logic [1:0] s_cnt;
  always_ff @(posedge clk) begin
    if (sq_reset) begin
      s_run <= 1'b0; s_cnt <= 2'd0; sq_valid_toggle <= 1'b0;
    end else if (sq_start) begin
      s_run <= 1'b1; s_cnt <= 2'd0; sq_out <= sq_in;
    end else if (s_run && !stall) begin
      if (s_cnt == 2'd2) begin
        s_cnt <= 2'd0;
        sq_valid_toggle <= ~sq_valid_toggle;
        sq_out <= mont_sq(sq_out);
      end else begin
        s_cnt <= s_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (sq_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // drive start in cycle 0; returns at cycle 1 sample point
  task automatic start(input logic [T_LEN-1:0] t, input logic [MOD_LEN-1:0] x);
    t_target = t; x_in = x; start_req = 1'b1;
    step(1);
    start_req = 1'b0;
  endtask

  // wait for done (which=0) or err (which=1); 'base' is the current cycle number
  task automatic wait_for(input int base, input int max, input bit which, output int cyc);
    cyc = -1;
    for (int k = base; k < base + max; k++) begin
      if ((which ? err : done) === 1'b1) begin cyc = k; return; end
      step(1);
    end
  endtask

  initial begin
    int d0, s0;
    reset = 1'b1;
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sq_start", sq_start, 0);
    chk("rst_sq_reset", sq_reset, 1);
    chk("rst_result", result, 0);
    chk("rst_iter", iter_count, 0);
    step(2);
    reset = 1'b0;
    step(1);

    // zero iterations: done in cycle 1, squarer never launched
    s0 = start_cnt;
    start(0, 16'h1234);
    chk("t0_done", done, 1);
    chk("t0_result", result, 16'h1234);
    chk("t0_busy", busy, 0);
    step(1);
    chk("t0_ready", ready, 1);
    chk("t0_no_sq_start", start_cnt, s0);

    // one iteration of Montgomery one: done at cycle 6
    start(1, R_MOD_N);
    chk("t1_sq_start", sq_start, 1);
    chk("t1_busy", busy, 1);
    wait_for(1, 30, 1'b0, at);
    chk("t1_done_cyc", at, 6);
    chk("t1_result", result, R_MOD_N);
    chk("t1_iter", iter_count, 1);
    step(1);
    chk("t1_done_pulse", done, 0);
    chk("t1_ready", ready, 1);

    // five iterations with a stray start_req mid-run
    gold = 16'd66;
    for (int i = 0; i < 5; i++) gold = mont_sq(gold);
    start(5, 16'd66);
    step(3);
    t_target = 1; x_in = 16'h0099; start_req = 1'b1;
    step(1);
    start_req = 1'b0;
    wait_for(5, 40, 1'b0, at);
    chk("t5_done_cyc", at, 18);
    chk("t5_result", result, gold);
    chk("t5_iter", iter_count, 5);
    step(2);

    // abort at cycle 12 of a 10-iteration run
    d0 = done_cnt;
    start(10, 16'd77);
    step(11);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("ab_sq_reset", sq_reset, 1);
    chk("ab_ready", ready, 1);
    chk("ab_busy", busy, 0);
    chk("ab_result", result, gold);
    step(1);
    chk("ab_sq_reset_pulse", sq_reset, 0);
    step(40);
    chk("ab_no_done", done_cnt, d0);

    // abort on the completion cycle (cycle 5 of a T=1 run) wins
    start(1, R_MOD_N);
    step(4);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abc_ready", ready, 1);
    chk("abc_result", result, gold);
    step(10);
    chk("abc_no_done", done_cnt, d0);

    // stalled squarer: watchdog fires at cycle 17
    stall = 1'b1;
    start(4, 16'h0010);
    wait_for(1, 40, 1'b1, at);
    chk("wd_err_cyc", at, 1 + WDOG + 1);
    chk("wd_ready", ready, 0);
    chk("wd_busy", busy, 0);
    chk("wd_sq_reset", sq_reset, 1);
    chk("wd_result", result, gold);
    step(5);
    chk("wd_err_sticky", err, 1);
    chk("wd_ready_hold", ready, 0);
    stall = 1'b0;
    start(0, 16'h0055);
    chk("wd_clr_err", err, 0);
    chk("wd_clr_done", done, 1);
    chk("wd_clr_result", result, 16'h0055);
    step(2);

    // maximum count runs to completion
    start(8'hFF, R_MOD_N);
    wait_for(1, 900, 1'b0, at);
    chk("max_done_cyc", at, 3 * 255 + 3);
    chk("max_iter", iter_count, 8'hFF);
    chk("max_result", result, R_MOD_N);
    step(2);

    // asynchronous reset at cycle 9 of an 8-iteration run
    d0 = done_cnt;
    start(8, 16'd66);
    step(8);
    reset = 1'b1;
    #1;
    chk("ar_ready", ready, 1);
    chk("ar_busy", busy, 0);
    chk("ar_sq_reset", sq_reset, 1);
    chk("ar_sq_start", sq_start, 0);
    chk("ar_result", result, 0);
    chk("ar_iter", iter_count, 0);
    chk("ar_err", err, 0);
    step(2);
    reset = 1'b0;
    step(30);
    chk("ar_no_done", done_cnt, d0);
    chk("ar_idle", ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
